jump_resolve_unit: RTL and testbench

- Decode-stage control-transfer resolver for the MIPS pipeline.
- Handles jr, jalr, beq and bne in D. Forwards rs/rt from M and W, stalls on E-stage and load-use hazards, and compares operands for branches.
- Issues a registered redirect to fetch over a valid/ack handshake.
- Successor to the single-source jr/jalr forwarding unit: parametrised widths, two operands, $0 exclusion, hazard FSM and handshake.

---
 rtl/jump_resolve_unit.sv | 133 +++++++++++++
 tb/tb_jump_resolve_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jump_resolve_unit.sv
// rtl/jump_resolve_unit.sv - decode-stage jr/jalr/beq/bne resolver with forwarding, hazard FSM and redirect handshake (optional counters: JRU_PERF_EN)
module jump_resolve_unit #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_d,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] pc_d,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic              regwrite_e,
  input  logic [REG_W-1:0]  rd_e,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [REG_W-1:0]  rd_m,
  input  logic [DATA_W-1:0] aluresult_m,
  input  logic              regwrite_w,
  input  logic [REG_W-1:0]  rd_w,
  input  logic [DATA_W-1:0] wdata_w,
  input  logic              redirect_ack,
  output logic              stall_d,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              is_link,
  output logic [CNT_W-1:0]  redirect_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT, PEND} state_t;

  state_t state, state_next;

  logic [5:0]        op, funct;
  logic [REG_W-1:0]  rs, rt;
  logic [15:0]       imm;
  logic              is_jr, is_jalr, is_beq, is_bne, ctl;
  logic              hz_rs, hz_rt, hz, taken, load_pc;
  logic [DATA_W-1:0] op_rs, op_rt, br_off, target;
  logic [4:0]        unused_shamt;

  assign op           = instr_d[31:26];
  assign funct        = instr_d[5:0];
  assign rs           = REG_W'(instr_d[25:21]);
  assign rt           = REG_W'(instr_d[20:16]);
  assign imm          = instr_d[15:0];
  assign unused_shamt = instr_d[10:6];

  assign is_jr   = (op == 6'h00) && (funct == 6'h08);
  assign is_jalr = (op == 6'h00) && (funct == 6'h09);
  assign is_beq  = (op == 6'h04);
  assign is_bne  = (op == 6'h05);
  assign ctl     = valid_d && (is_jr || is_jalr || is_beq || is_bne);
  assign is_link = valid_d && is_jalr;

  // Forward one source: $0 first, then E hazard, M load hazard, M ALU, W, regfile.
  function automatic logic [DATA_W:0] fwd(input logic [REG_W-1:0] src,
                                          input logic [DATA_W-1:0] rf);
    if (src == '0)                                   fwd = '0;
    else if (regwrite_e && rd_e == src)              fwd = {1'b1, {DATA_W{1'b0}}};
    else if (regwrite_m && memtoreg_m && rd_m == src) fwd = {1'b1, {DATA_W{1'b0}}};
    else if (regwrite_m && rd_m == src)              fwd = {1'b0, aluresult_m};
    else if (regwrite_w && rd_w == src)              fwd = {1'b0, wdata_w};
    else                                             fwd = {1'b0, rf};
  endfunction

  // Operand selection, hazard, target and taken evaluation for the instruction in D.
  always_comb begin
    {hz_rs, op_rs} = fwd(rs, rdata1);
    {hz_rt, op_rt} = fwd(rt, rdata2);
    hz     = hz_rs || ((is_beq || is_bne) && hz_rt);
    br_off = {{(DATA_W-18){imm[15]}}, imm, 2'b00};
    target = (is_jr || is_jalr) ? op_rs : (pc_d + DATA_W'(4) + br_off);
    taken  = is_jr || is_jalr || (is_beq && (op_rs == op_rt)) || (is_bne && (op_rs != op_rt));
  end

  // Next-state and stall decisions; WAIT re-resolves exactly like IDLE once the hazard clears.
  always_comb begin
    state_next = state;
    stall_d    = 1'b0;
    load_pc    = 1'b0;
    case (state)
      IDLE, WAIT: begin
        if (ctl && hz) begin
          stall_d    = 1'b1;
          state_next = WAIT;
        end else if (ctl && taken) begin
          load_pc    = 1'b1;
          state_next = PEND;
        end else begin
          state_next = IDLE;
        end
      end
      PEND: begin
        stall_d = ctl;
        if (redirect_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and the redirect target, held stable while pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      redirect_pc <= '0;
    end else begin
      state <= state_next;
      if (load_pc) redirect_pc <= target;
    end
  end

  assign redirect_valid = (state == PEND);

`ifdef JRU_PERF_EN
  // Redirect and stall-cycle counters, free-running and wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (load_pc) redirect_cnt <= redirect_cnt + CNT_W'(1);
      if (stall_d) stall_cnt    <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign redirect_cnt = '0;
  assign stall_cnt    = '0;
`endif

endmodule

// File: tb/tb_jump_resolve_unit.sv
// tb/tb_jump_resolve_unit.sv - randomized self-checking bench for jump_resolve_unit
module tb_jump_resolve_unit;

`ifdef JRU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 0, reset = 0;
  logic [31:0] instr_d, pc_d, rdata1, rdata2, aluresult_m, wdata_w;
  logic        valid_d, regwrite_e, regwrite_m, memtoreg_m, regwrite_w, redirect_ack;
  logic [4:0]  rd_e, rd_m, rd_w;
  logic        stall_d, redirect_valid, is_link;
  logic [31:0] redirect_pc, redirect_cnt, stall_cnt;

  int n_cmp = 0, n_bad = 0;

  // model: is a redirect outstanding, its target, and event counters
  bit          m_pend;
  logic [31:0] m_pc, m_r, m_s;

  jump_resolve_unit dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .pc_d(pc_d),
    .rdata1(rdata1), .rdata2(rdata2), .regwrite_e(regwrite_e), .rd_e(rd_e),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .rd_m(rd_m), .aluresult_m(aluresult_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .wdata_w(wdata_w), .redirect_ack(redirect_ack),
    .stall_d(stall_d), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .is_link(is_link), .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_jr(input int rs, input bit link);
    mk_jr = {6'h00, 5'(rs), 15'h0, (link ? 6'h09 : 6'h08)};
  endfunction

  function automatic logic [31:0] mk_br(input bit ne, input int rs, input int rt, input logic [15:0] imm);
    mk_br = {(ne ? 6'h05 : 6'h04), 5'(rs), 5'(rt), imm};
  endfunction

  // Value the architecture sees for register src right now; hz when not yet available.
  function automatic void operand(input int src, input logic [31:0] rf, output bit hz, output logic [31:0] v);
    hz = 0; v = rf;
    if (src == 0) v = 0;
    else if (regwrite_e && rd_e == src) hz = 1;
    else if (regwrite_m && rd_m == src) begin
      if (memtoreg_m) hz = 1; else v = aluresult_m;
    end
    else if (regwrite_w && rd_w == src) v = wdata_w;
  endfunction

  task automatic model_reset();
    m_pend = 0; m_pc = 0; m_r = 0; m_s = 0;
  endtask

  task automatic idle_inputs();
    instr_d = 0; valid_d = 0; pc_d = 0; rdata1 = 0; rdata2 = 0; aluresult_m = 0; wdata_w = 0;
    regwrite_e = 0; regwrite_m = 0; memtoreg_m = 0; regwrite_w = 0; redirect_ack = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
  endtask

  // Check all outputs against the model for this cycle, then advance one clock.
  task automatic cycle();
    int op, fn, kind, rs, rt;
    bit h1, h2, hz, tk, ctl, exp_stall;
    logic [31:0] v1, v2, tgt;
    longint off;
    #2;
    op = int'(instr_d[31:26]); fn = int'(instr_d[5:0]);
    rs = int'(instr_d[25:21]); rt = int'(instr_d[20:16]);
    kind = 0;
    if (op == 0 && fn == 8) kind = 1;
    else if (op == 0 && fn == 9) kind = 2;
    else if (op == 4) kind = 3;
    else if (op == 5) kind = 4;
    ctl = valid_d && kind != 0;
    operand(rs, rdata1, h1, v1);
    operand(rt, rdata2, h2, v2);
    hz = h1 || (kind >= 3 && h2);
    off = longint'($signed(instr_d[15:0])) * 4;
    tgt = (kind <= 2) ? v1 : 32'(longint'(pc_d) + 4 + off);
    tk = (kind <= 2) || (kind == 3 && v1 == v2) || (kind == 4 && v1 != v2);
    exp_stall = ctl && (m_pend || hz);
    check("stall_d", stall_d, exp_stall);
    check("is_link", is_link, valid_d && kind == 2);
    check("redirect_valid", redirect_valid, m_pend);
    check("redirect_pc", redirect_pc, m_pc);
    check("redirect_cnt", redirect_cnt, PERF ? m_r : 32'h0);
    check("stall_cnt", stall_cnt, PERF ? m_s : 32'h0);
    @(posedge clk); #1;
    if (reset) model_reset();
    else begin
      if (exp_stall) m_s = m_s + 1;
      if (m_pend) begin
        if (redirect_ack) m_pend = 0;
      end else if (ctl && !hz && tk) begin
        m_pend = 1; m_pc = tgt; m_r = m_r + 1;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    idle_inputs();
    redirect_ack = 1;
    while (m_pend && n < 4) begin cycle(); n++; end
    redirect_ack = 0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1;
    #3;
    check("reset_rvalid", redirect_valid, 0);
    check("reset_stall", stall_d, 0);
    @(posedge clk); #1;
    reset = 0;
    cycle();

    // jr $5 to 0x00400100, held across three unacked cycles
    instr_d = mk_jr(5, 0); valid_d = 1; rdata1 = 32'h00400100;
    cycle();
    idle_inputs();
    #1 check("t1_rvalid", redirect_valid, 1);
    check("t1_rpc", redirect_pc, 32'h00400100);
    for (int i = 0; i < 3; i++) begin
      rdata1 = $urandom;
      cycle();
      check("t1_hold", redirect_pc, 32'h00400100);
    end
    redirect_ack = 1; cycle(); redirect_ack = 0;
    #1 check("t1_acked", redirect_valid, 0);
    cycle();

    // jalr $8: M ALU result wins over W
    instr_d = mk_jr(8, 1); valid_d = 1; regwrite_m = 1; rd_m = 8; aluresult_m = 32'h3000;
    regwrite_w = 1; rd_w = 8; wdata_w = 32'h4000;
    #1 check("t2_link", is_link, 1);
    cycle();
    #1 check("t2_rpc", redirect_pc, 32'h3000);
    drain();

    // jr $9 behind a load in M, then the load in W
    instr_d = mk_jr(9, 0); valid_d = 1; regwrite_m = 1; memtoreg_m = 1; rd_m = 9;
    #1 check("t3_stall", stall_d, 1);
    cycle();
    regwrite_m = 0; memtoreg_m = 0; regwrite_w = 1; rd_w = 9; wdata_w = 32'h5000;
    #1 check("t3_nostall", stall_d, 0);
    cycle();
    #1 check("t3_rpc", redirect_pc, 32'h5000);
    drain();

    // beq $3,$0 with negative offset: taken to itself; bne: not taken
    instr_d = mk_br(0, 3, 0, 16'hFFFF); valid_d = 1; pc_d = 32'h3000;
    cycle();
    #1 check("t4_beq_rpc", redirect_pc, 32'h3000);
    drain();
    instr_d = mk_br(1, 3, 0, 16'hFFFF); valid_d = 1; pc_d = 32'h3000;
    cycle();
    #1 check("t4_bne_rvalid", redirect_valid, 0);
    idle_inputs(); cycle();

    // jr $0 ignores the E-stage write to $0
    instr_d = mk_jr(0, 0); valid_d = 1; regwrite_e = 1; rd_e = 0; rdata1 = 32'hdead;
    #1 check("t5_stall", stall_d, 0);
    cycle();
    #1 check("t5_rpc", redirect_pc, 0);
    drain();

    // reset in WAIT: hazard persists, so stall follows the IDLE rule
    instr_d = mk_jr(9, 0); valid_d = 1; regwrite_e = 1; rd_e = 9;
    cycle();
    reset = 1; model_reset();
    #1 check("t6_wait_rvalid", redirect_valid, 0);
    check("t6_wait_stall", stall_d, 1);
    cycle(); reset = 0;
    // reset in PEND
    idle_inputs(); instr_d = mk_jr(5, 0); valid_d = 1; rdata1 = 32'h1234;
    cycle();
    #1 check("t6_pend_rvalid", redirect_valid, 1);
    reset = 1; model_reset();
    #1 check("t6_pend_clr", redirect_valid, 0);
    check("t6_pend_rpc", redirect_pc, 0);
    cycle(); reset = 0;

    // two redirects, three stall cycles
    idle_inputs(); instr_d = mk_jr(5, 0); valid_d = 1; rdata1 = 32'h100;
    cycle();
    redirect_ack = 1; cycle(); redirect_ack = 0;
    regwrite_e = 1; rd_e = 5; cycle(); cycle();
    regwrite_e = 0; cycle();
    idle_inputs();
    #1 check("t7_rcnt", redirect_cnt, PERF ? 32'd2 : 32'd0);
    check("t7_scnt", stall_cnt, PERF ? 32'd3 : 32'd0);
    reset = 1; model_reset();
    #1 check("t7_rcnt_clr", redirect_cnt, 0);
    check("t7_scnt_clr", stall_cnt, 0);
    cycle(); reset = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int k;
      k = $urandom_range(0, 5);
      case (k)
        0: instr_d = mk_jr($urandom_range(0, 3), 0);
        1: instr_d = mk_jr($urandom_range(0, 3), 1);
        2: instr_d = mk_br(0, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        3: instr_d = mk_br(1, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom));
        4: instr_d = {6'h23, 26'($urandom)};
        default: instr_d = {6'h00, 20'($urandom), 6'h20};
      endcase
      valid_d = ($urandom_range(0, 7) != 0);
      pc_d = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      rdata1 = 32'($urandom_range(0, 2)); rdata2 = 32'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) rdata1 = $urandom;
      aluresult_m = 32'($urandom_range(0, 2)); wdata_w = $urandom;
      regwrite_e = ($urandom_range(0, 3) == 0); rd_e = 5'($urandom_range(0, 3));
      regwrite_m = ($urandom_range(0, 2) == 0); rd_m = 5'($urandom_range(0, 3));
      memtoreg_m = $urandom_range(0, 1) == 1;
      regwrite_w = ($urandom_range(0, 1) == 1); rd_w = 5'($urandom_range(0, 3));
      redirect_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) begin reset = 1; model_reset(); end
      cycle();
      reset = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
